// File: rtl/sysio_axil_hub_if.sv
// AXI4-Lite slave-side bundle for the system-IO hub.
// The hub takes the slave modport; the interconnect (or a bench) drives the master side.
interface sysio_axil_hub_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] s_awaddr;
  logic              s_awvalid;
  logic              s_awready;
  logic [31:0]       s_wdata;
  logic [3:0]        s_wstrb;
  logic              s_wvalid;
  logic              s_wready;
  logic [1:0]        s_bresp;
  logic              s_bvalid;
  logic              s_bready;
  logic [ADDR_W-1:0] s_araddr;
  logic              s_arvalid;
  logic              s_arready;
  logic [31:0]       s_rdata;
  logic [1:0]        s_rresp;
  logic              s_rvalid;
  logic              s_rready;

  modport slave (
    input  s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
           s_araddr, s_arvalid, s_rready,
    output s_awready, s_wready, s_bresp, s_bvalid,
           s_arready, s_rdata, s_rresp, s_rvalid
  );

  modport master (
    output s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
           s_araddr, s_arvalid, s_rready,
    input  s_awready, s_wready, s_bresp, s_bvalid,
           s_arready, s_rdata, s_rresp, s_rvalid
  );
endinterface

// File: rtl/sysio_axil_hub.sv
// AXI4-Lite slave hub splitting one bus into SLOT_NUM simple peripheral register ports.
// Slot index = addr[SLOT_AW +: clog2(SLOT_NUM)]; unpopulated/out-of-range slots answer DECERR.
// Optional macro SYSIO_RDATA_LATCH_EN: register peripheral read data one cycle after p_rd,
// so s_rvalid comes at T+2 and the returned data no longer depends on the peripheral holding it.
//
// Write FSM:
//   state     | meaning
//   W_COLLECT | accepting AW and W independently into hold registers
//   W_RESP    | peripheral write issued on entry, B response pending
module sysio_axil_hub #(
  parameter int          ADDR_W    = 32,
  parameter int          SLOT_NUM  = 16,
  parameter int          SLOT_AW   = 8,
  parameter logic [31:0] SLOT_MASK = 32'h0000_801F
) (
  input  logic                     clk,
  input  logic                     rst_n,
  sysio_axil_hub_if.slave          s,
  output logic [SLOT_AW-1:0]       p_waddr_o,
  output logic [31:0]              p_wdata_o,
  output logic [3:0]               p_wsel_o,
  output logic [SLOT_NUM-1:0]      p_we_o,
  output logic [SLOT_AW-1:0]       p_raddr_o,
  output logic [SLOT_NUM-1:0]      p_rd_o,
  input  logic [SLOT_NUM*32-1:0]   p_rdata_i
);

  localparam int         SIW         = $clog2(SLOT_NUM);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic {W_COLLECT, W_RESP} wstate_e;

  function automatic logic slot_ok(input logic [SIW-1:0] idx);
    logic [31:0] m;
    m = SLOT_MASK >> idx;
    return (int'(idx) < SLOT_NUM) && m[0];
  endfunction

  function automatic logic [SLOT_NUM-1:0] slot_onehot(input logic [SIW-1:0] idx);
    return {{(SLOT_NUM-1){1'b0}}, 1'b1} << idx;
  endfunction

  // Only the slot field and word offset matter; upper and byte-lane bits are ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{s.s_awaddr, s.s_araddr};

  // ---------------- write path ----------------
  wstate_e                w_state_q, w_state_d;
  logic                   aw_held_q, aw_held_d;
  logic [SIW-1:0]         aw_idx_q, aw_idx_d;
  logic [SLOT_AW-3:0]     aw_off_q, aw_off_d;
  logic                   w_held_q, w_held_d;
  logic [31:0]            w_data_q, w_data_d;
  logic [3:0]             w_strb_q, w_strb_d;
  logic [SLOT_NUM-1:0]    we_q, we_d;
  logic [1:0]             bresp_q, bresp_d;
  logic                   aw_hs, w_hs;

  assign s.s_awready = (w_state_q == W_COLLECT) & ~aw_held_q;
  assign s.s_wready  = (w_state_q == W_COLLECT) & ~w_held_q;
  assign s.s_bvalid  = (w_state_q == W_RESP);
  assign s.s_bresp   = bresp_q;
  assign aw_hs       = s.s_awvalid & s.s_awready;
  assign w_hs        = s.s_wvalid & s.s_wready;

  assign p_we_o    = we_q;
  assign p_waddr_o = {aw_off_q, 2'b00};
  assign p_wdata_o = w_data_q;
  assign p_wsel_o  = w_strb_q;

  // Next-state: capture AW/W independently; issue the write pulse on the edge both are in.
  always_comb begin
    w_state_d = w_state_q;
    aw_held_d = aw_held_q;
    aw_idx_d  = aw_idx_q;
    aw_off_d  = aw_off_q;
    w_held_d  = w_held_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    we_d      = '0;
    bresp_d   = bresp_q;
    case (w_state_q)
      W_COLLECT: begin
        if (aw_hs) begin
          aw_held_d = 1'b1;
          aw_idx_d  = s.s_awaddr[SLOT_AW +: SIW];
          aw_off_d  = s.s_awaddr[SLOT_AW-1:2];
        end
        if (w_hs) begin
          w_held_d = 1'b1;
          w_data_d = s.s_wdata;
          w_strb_d = s.s_wstrb;
        end
        if (aw_held_d && w_held_d) begin
          w_state_d = W_RESP;
          if (slot_ok(aw_idx_d)) begin
            we_d    = slot_onehot(aw_idx_d);
            bresp_d = RESP_OKAY;
          end else begin
            bresp_d = RESP_DECERR;
          end
        end
      end
      W_RESP: begin
        if (s.s_bready) begin
          w_state_d = W_COLLECT;
          aw_held_d = 1'b0;
          aw_idx_d  = '0;
          aw_off_d  = '0;
          w_held_d  = 1'b0;
          w_data_d  = '0;
          w_strb_d  = '0;
          bresp_d   = RESP_OKAY;
        end
      end
      default: w_state_d = W_COLLECT;
    endcase
  end

  // Write-path registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_state_q <= W_COLLECT;
      aw_held_q <= 1'b0;
      aw_idx_q  <= '0;
      aw_off_q  <= '0;
      w_held_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      we_q      <= '0;
      bresp_q   <= RESP_OKAY;
    end else begin
      w_state_q <= w_state_d;
      aw_held_q <= aw_held_d;
      aw_idx_q  <= aw_idx_d;
      aw_off_q  <= aw_off_d;
      w_held_q  <= w_held_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      we_q      <= we_d;
      bresp_q   <= bresp_d;
    end
  end

  // ---------------- read path ----------------
  logic                ar_hs;
  logic [SIW-1:0]      ar_idx;
  logic                ar_ok;
  logic                rvalid_q;
  logic [SIW-1:0]      rsel_q;
  logic                rerr_q;
  logic [31:0]         rdata_mux;

  assign ar_hs     = s.s_arvalid & s.s_arready;
  assign ar_idx    = s.s_araddr[SLOT_AW +: SIW];
  assign ar_ok     = slot_ok(ar_idx);
  // rst_n gate keeps a read strobe from reaching a peripheral while the hub is discarding state.
  assign p_rd_o    = (ar_hs && ar_ok && rst_n) ? slot_onehot(ar_idx) : '0;
  assign p_raddr_o = ar_hs ? {s.s_araddr[SLOT_AW-1:2], 2'b00} : '0;
  assign s.s_rvalid = rvalid_q;

  // Select the addressed slot's data bus using the registered slot index.
  always_comb begin
    rdata_mux = '0;
    for (int i = 0; i < SLOT_NUM; i++) begin
      if (rsel_q == SIW'(i)) rdata_mux = p_rdata_i[i*32 +: 32];
    end
  end

`ifdef SYSIO_RDATA_LATCH_EN
  logic        rd_busy_q;
  logic [31:0] rdata_q;
  logic [1:0]  rresp_q;

  assign s.s_arready = ~rd_busy_q & (~rvalid_q | s.s_rready);
  assign s.s_rdata   = rdata_q;
  assign s.s_rresp   = rresp_q;

  // Latch peripheral data the cycle after p_rd, then present it until accepted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_busy_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rsel_q    <= '0;
      rerr_q    <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      if (ar_hs) begin
        rd_busy_q <= 1'b1;
        rsel_q    <= ar_idx;
        rerr_q    <= ~ar_ok;
      end
      if (rd_busy_q) begin
        rd_busy_q <= 1'b0;
        rvalid_q  <= 1'b1;
        rdata_q   <= rerr_q ? 32'h0 : rdata_mux;
        rresp_q   <= rerr_q ? RESP_DECERR : RESP_OKAY;
      end else if (rvalid_q && s.s_rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end
`else
  assign s.s_arready = ~rvalid_q | s.s_rready;
  assign s.s_rdata   = (rvalid_q && !rerr_q) ? rdata_mux : 32'h0;
  assign s.s_rresp   = (rvalid_q && rerr_q) ? RESP_DECERR : RESP_OKAY;

  // Pipelined read: each AR handshake yields a beat the next cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rvalid_q <= 1'b0;
      rsel_q   <= '0;
      rerr_q   <= 1'b0;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rsel_q   <= ar_idx;
      rerr_q   <= ~ar_ok;
    end else if (s.s_rready) begin
      rvalid_q <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_sysio_axil_hub.sv
// Self-checking bench for sysio_axil_hub (default build): directed scenarios plus
// randomized writes/read bursts checked against an address-rule reference model.
module tb_sysio_axil_hub;
  localparam logic [15:0] MASK = 16'h801F;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sysio_axil_hub_if #(.ADDR_W(32)) axi ();

  logic [7:0]   p_waddr, p_raddr;
  logic [31:0]  p_wdata;
  logic [3:0]   p_wsel;
  logic [15:0]  p_we, p_rd;
  logic [511:0] p_rdata;
  logic [31:0]  slot_val [16];

  sysio_axil_hub dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s         (axi.slave),
    .p_waddr_o (p_waddr),
    .p_wdata_o (p_wdata),
    .p_wsel_o  (p_wsel),
    .p_we_o    (p_we),
    .p_raddr_o (p_raddr),
    .p_rd_o    (p_rd),
    .p_rdata_i (p_rdata)
  );

  always_comb begin
    p_rdata = '0;
    for (int i = 0; i < 16; i++) p_rdata[i*32 +: 32] = slot_val[i];
  end

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  // Reference model: pure address arithmetic from the slot map.
  function automatic int slot_of(input logic [31:0] a);
    return int'((a >> 8) & 32'hF);
  endfunction
  function automatic bit populated(input logic [31:0] a);
    return MASK[slot_of(a)];
  endfunction
  function automatic logic [15:0] exp_strobe(input logic [31:0] a);
    return populated(a) ? 16'(2 ** slot_of(a)) : 16'h0;
  endfunction
  function automatic logic [1:0] exp_resp(input logic [31:0] a);
    return populated(a) ? 2'b00 : 2'b11;
  endfunction
  function automatic logic [31:0] exp_rdata(input logic [31:0] a);
    return populated(a) ? slot_val[slot_of(a)] : 32'h0;
  endfunction

  // Strobes must never be more than one-hot or hit an unpopulated slot.
  always @(negedge clk) begin
    #2;
    if (rst_n) begin
      chk("we_onehot", 64'($countones(p_we) <= 1), 64'(1));
      chk("rd_onehot", 64'($countones(p_rd) <= 1), 64'(1));
      chk("we_unpop", p_we & ~MASK, 0);
      chk("rd_unpop", p_rd & ~MASK, 0);
    end
  end

  // skew > 0: W leads AW by skew cycles; skew < 0: AW leads W.
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st,
                          input int skew, input int bwait);
    int lead;
    lead = (skew < 0) ? -skew : skew;
    @(negedge clk);
    if (skew >= 0) begin
      axi.s_wvalid = 1'b1; axi.s_wdata = d; axi.s_wstrb = st;
    end
    if (skew <= 0) begin
      axi.s_awvalid = 1'b1; axi.s_awaddr = a;
    end
    #1;
    if (skew >= 0) chk("wready_idle", axi.s_wready, 1);
    if (skew <= 0) chk("awready_idle", axi.s_awready, 1);
    for (int k = 0; k < lead; k++) begin
      @(negedge clk);
      axi.s_awvalid = 1'b0; axi.s_wvalid = 1'b0;
      #1;
      chk("we_early", p_we, 0);
      chk("bvalid_early", axi.s_bvalid, 0);
      chk("wready_held", axi.s_wready, skew < 0);
      chk("awready_held", axi.s_awready, skew > 0);
    end
    if (skew > 0) begin
      axi.s_awvalid = 1'b1; axi.s_awaddr = a;
    end else if (skew < 0) begin
      axi.s_wvalid = 1'b1; axi.s_wdata = d; axi.s_wstrb = st;
    end
    @(negedge clk);
    axi.s_awvalid = 1'b0; axi.s_wvalid = 1'b0;
    #1;
    chk("we_pulse", p_we, exp_strobe(a));
    chk("bvalid", axi.s_bvalid, 1);
    chk("bresp", axi.s_bresp, exp_resp(a));
    chk("awready_resp", axi.s_awready, 0);
    chk("wready_resp", axi.s_wready, 0);
    if (populated(a)) begin
      chk("waddr", p_waddr, a[7:0] & 8'hFC);
      chk("wdata", p_wdata, d);
      chk("wsel", p_wsel, st);
    end
    for (int k = 0; k < bwait; k++) begin
      @(negedge clk);
      #1;
      chk("we_once", p_we, 0);
      chk("bvalid_hold", axi.s_bvalid, 1);
      chk("awready_wait", axi.s_awready, 0);
    end
    axi.s_bready = 1'b1;
    @(negedge clk);
    axi.s_bready = 1'b0;
    #1;
    chk("bvalid_clr", axi.s_bvalid, 0);
    chk("awready_back", axi.s_awready, 1);
    chk("wready_back", axi.s_wready, 1);
  endtask

  // Back-to-back reads with rready held high: one beat per cycle.
  task automatic do_reads(input logic [31:0] addrs[$]);
    axi.s_rready = 1'b1;
    for (int i = 0; i < addrs.size(); i++) begin
      @(negedge clk);
      axi.s_arvalid = 1'b1; axi.s_araddr = addrs[i];
      #1;
      chk("arready", axi.s_arready, 1);
      chk("rd_pulse", p_rd, exp_strobe(addrs[i]));
      chk("raddr", p_raddr, addrs[i][7:0] & 8'hFC);
      if (i > 0) begin
        chk("rvalid_b2b", axi.s_rvalid, 1);
        chk("rdata_b2b", axi.s_rdata, exp_rdata(addrs[i-1]));
        chk("rresp_b2b", axi.s_rresp, exp_resp(addrs[i-1]));
      end
    end
    @(negedge clk);
    axi.s_arvalid = 1'b0;
    #1;
    chk("rvalid_last", axi.s_rvalid, 1);
    chk("rdata_last", axi.s_rdata, exp_rdata(addrs[addrs.size()-1]));
    chk("rresp_last", axi.s_rresp, exp_resp(addrs[addrs.size()-1]));
    @(negedge clk);
    #1;
    chk("rvalid_clr", axi.s_rvalid, 0);
    axi.s_rready = 1'b0;
  endtask

  initial begin
    logic [31:0] q[$];
    logic [31:0] a, d;
    axi.s_awaddr = '0; axi.s_awvalid = 0; axi.s_wdata = '0; axi.s_wstrb = '0;
    axi.s_wvalid = 0; axi.s_bready = 0; axi.s_araddr = '0; axi.s_arvalid = 0; axi.s_rready = 0;
    for (int i = 0; i < 16; i++) slot_val[i] = $urandom();

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_awready", axi.s_awready, 1);
    chk("rst_wready", axi.s_wready, 1);
    chk("rst_arready", axi.s_arready, 1);
    chk("rst_bvalid", axi.s_bvalid, 0);
    chk("rst_rvalid", axi.s_rvalid, 0);
    chk("rst_we", p_we, 0);
    chk("rst_rdata", axi.s_rdata, 0);
    rst_n = 1'b1;

    // Directed scenarios
    do_write(32'h0000_0404, 32'h0000_00A5, 4'hF, 0, 0);
    chk("slot4_strobe", exp_strobe(32'h0000_0404), 16'h0010);
    do_write(32'h0000_0104, 32'hCAFE_0001, 4'h3, 3, 2);
    slot_val[15] = 32'h1234_5678;
    q = '{32'h0000_0F00};
    do_reads(q);
    q = '{32'h0000_0000, 32'h0000_0100, 32'h0000_0200, 32'h0000_0400};
    do_reads(q);

    // Unpopulated slot 7: concurrent read and write both return DECERR
    @(negedge clk);
    axi.s_awvalid = 1; axi.s_awaddr = 32'h0700; axi.s_wvalid = 1; axi.s_wdata = 32'h55; axi.s_wstrb = 4'hF;
    axi.s_arvalid = 1; axi.s_araddr = 32'h0700;
    #1;
    chk("dec_rd", p_rd, 0);
    @(negedge clk);
    axi.s_awvalid = 0; axi.s_wvalid = 0; axi.s_arvalid = 0;
    #1;
    chk("dec_we", p_we, 0);
    chk("dec_bresp", axi.s_bresp, 2'b11);
    chk("dec_rresp", axi.s_rresp, 2'b11);
    chk("dec_rdata", axi.s_rdata, 0);
    axi.s_bready = 1; axi.s_rready = 1;
    @(negedge clk);
    axi.s_bready = 0; axi.s_rready = 0;
    #1;
    chk("dec_bclr", axi.s_bvalid, 0);
    chk("dec_rclr", axi.s_rvalid, 0);

    // Read stall with rready low: arready drops and data holds
    @(negedge clk);
    axi.s_arvalid = 1; axi.s_araddr = 32'h0300; axi.s_rready = 1;
    @(negedge clk);
    axi.s_rready = 0; axi.s_araddr = 32'h0F04;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("stall_arready", axi.s_arready, 0);
      chk("stall_rd", p_rd, 0);
      chk("stall_rdata", axi.s_rdata, slot_val[3]);
      @(negedge clk);
    end
    axi.s_rready = 1;
    #1;
    chk("unstall_rd", p_rd, 16'h8000);
    @(negedge clk);
    axi.s_arvalid = 0;
    #1;
    chk("unstall_rdata", axi.s_rdata, slot_val[15]);
    @(negedge clk);
    axi.s_rready = 0;

    // Reset with a write in W_RESP and a read beat pending
    @(negedge clk);
    axi.s_awvalid = 1; axi.s_awaddr = 32'h0300; axi.s_wvalid = 1; axi.s_wdata = 32'h77; axi.s_wstrb = 4'h1;
    axi.s_arvalid = 1; axi.s_araddr = 32'h0100;
    @(negedge clk);
    axi.s_awvalid = 0; axi.s_wvalid = 0; axi.s_arvalid = 0;
    #1;
    chk("pre_rst_bvalid", axi.s_bvalid, 1);
    chk("pre_rst_rvalid", axi.s_rvalid, 1);
    rst_n = 0;
    @(negedge clk);
    #1;
    chk("mid_rst_bvalid", axi.s_bvalid, 0);
    chk("mid_rst_rvalid", axi.s_rvalid, 0);
    chk("mid_rst_we", p_we, 0);
    chk("mid_rst_awready", axi.s_awready, 1);
    chk("mid_rst_wready", axi.s_wready, 1);
    rst_n = 1;
    do_write(32'h0000_0208, 32'hDEAD_BEEF, 4'hC, -2, 1);

    // Randomized traffic
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 2))
        0: begin
          a = $urandom(); a[11:8] = 4'($urandom_range(0, 15));
          d = $urandom();
          do_write(a, d, 4'($urandom_range(0, 15)), $urandom_range(0, 6) - 3, $urandom_range(0, 2));
        end
        1: begin
          q = {};
          for (int k = 0; k < $urandom_range(1, 4); k++) begin
            a = $urandom(); a[11:8] = 4'($urandom_range(0, 15));
            q.push_back(a);
          end
          do_reads(q);
        end
        default: slot_val[$urandom_range(0, 15)] = $urandom();
      endcase
    end

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
